// File: rtl/sha256d_nonce_sequencer.sv
// sha256d_nonce_sequencer: scans a nonce range with double SHA-256 on one compress core.
// Define SHA256D_TARGET_CMP_EN for a full 256-bit target compare; default is the H7==0 prefilter.
module sha256d_nonce_sequencer #(
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [255:0]       job_midstate,
  input  logic [95:0]        job_tail,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [NONCE_W-1:0] job_nonce_count,
  input  logic [255:0]       job_target,
  input  logic               abort,
  output logic               busy,
  output logic               job_done,
  output logic               found_valid,
  input  logic               found_ready,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [255:0]       found_hash,
  output logic [NONCE_W-1:0] hash_count,
  output logic               cmp_start,
  output logic [255:0]       cmp_state_i,
  output logic [511:0]       cmp_block_i,
  input  logic               cmp_busy,
  input  logic               cmp_done,
  input  logic [255:0]       cmp_state_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] H1_GO   = 3'd1;
  localparam logic [2:0] H1_WAIT = 3'd2;
  localparam logic [2:0] H2_GO   = 3'd3;
  localparam logic [2:0] H2_WAIT = 3'd4;
  localparam logic [2:0] CHECK   = 3'd5;
  localparam logic [2:0] REPORT  = 3'd6;
  localparam logic [2:0] DRAIN   = 3'd7;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic [2:0]         state;
  logic [255:0]       mid;
  logic [255:0]       d2;
  logic [95:0]        tail;
  logic [NONCE_W-1:0] nonce;
  logic [NONCE_W-1:0] remaining;
  logic [NONCE_W-1:0] nonce_nx;
  logic               hit;
  logic               last;
  logic               advance;
  logic               in_core;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Second header chunk: tail, nonce (header is little-endian), pad, 640-bit length.
  function automatic logic [511:0] h1_block(
    input logic [95:0] t,
    input logic [31:0] n
  );
    return {t, bswap32(n), 32'h80000000, 288'd0, 64'd640};
  endfunction

`ifdef SHA256D_TARGET_CMP_EN
  logic [255:0] target;
  logic [255:0] v;

  always_comb begin
    v = '0;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = d2[255-8*i -: 8];
  end

  assign hit = v <= target;
`else
  logic unused_target;

  assign unused_target = ^job_target;
  assign hit = d2[31:0] == 32'h0;
`endif

  assign job_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign cmp_start = (state == H1_GO || state == H2_GO)
                   && !cmp_busy && !abort;
  assign nonce_nx  = nonce + NONCE_W'(1);
  assign last      = remaining == NONCE_W'(1);
  assign in_core   = state == H1_WAIT || state == H2_WAIT || cmp_busy;
  assign advance   = !abort
                   && ((state == CHECK && !hit)
                   || (state == REPORT && found_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mid         <= '0;
      d2          <= '0;
      tail        <= '0;
      nonce       <= '0;
      remaining   <= '0;
      job_done    <= 1'b0;
      found_valid <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      hash_count  <= '0;
      cmp_state_i <= '0;
      cmp_block_i <= '0;
`ifdef SHA256D_TARGET_CMP_EN
      target      <= '0;
`endif
    end else begin
      job_done <= 1'b0;
      if (abort && state != IDLE) begin
        found_valid <= 1'b0;
        // A core result arriving in the abort cycle is dropped here, not drained.
        if (state == DRAIN) begin
          if (cmp_done) begin
            job_done <= 1'b1;
            state    <= IDLE;
          end
        end else if (in_core && !cmp_done) begin
          state <= DRAIN;
        end else begin
          job_done <= 1'b1;
          state    <= IDLE;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (job_valid) begin
              mid         <= job_midstate;
              tail        <= job_tail;
              nonce       <= job_nonce_start;
              remaining   <= job_nonce_count;
              cmp_state_i <= job_midstate;
              cmp_block_i <= h1_block(job_tail, job_nonce_start);
`ifdef SHA256D_TARGET_CMP_EN
              target      <= job_target;
`endif
              if (job_nonce_count == '0) job_done <= 1'b1;
              else state <= H1_GO;
            end
          end
          H1_GO: if (!cmp_busy) state <= H1_WAIT;
          H1_WAIT: begin
            if (cmp_done) begin
              cmp_state_i <= IV;
              cmp_block_i <= {cmp_state_o, 32'h80000000, 160'd0, 64'd256};
              state       <= H2_GO;
            end
          end
          H2_GO: if (!cmp_busy) state <= H2_WAIT;
          H2_WAIT: begin
            if (cmp_done) begin
              d2         <= cmp_state_o;
              hash_count <= hash_count + NONCE_W'(1);
              state      <= CHECK;
            end
          end
          CHECK: begin
            if (hit) begin
              found_valid <= 1'b1;
              found_nonce <= nonce;
              found_hash  <= d2;
              state       <= REPORT;
            end
          end
          REPORT: if (found_ready) found_valid <= 1'b0;
          DRAIN: begin
            if (cmp_done) begin
              job_done <= 1'b1;
              state    <= IDLE;
            end
          end
        endcase

        if (advance) begin
          nonce       <= nonce_nx;
          remaining   <= remaining - NONCE_W'(1);
          cmp_state_i <= mid;
          cmp_block_i <= h1_block(tail, nonce_nx);
          if (last) begin
            job_done <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= H1_GO;
          end
        end
      end
    end
  end

endmodule
